// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle add/subtract engine: one shared 4-bit lookahead-carry slice processes the
// operands one nibble per clock, LSB nibble first, with the slice carry-out registered.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full lookahead expansion of the four in-slice carries {c3,c2,c1,c0} from ci.
  function automatic logic [3:0] cla_carries(input logic [3:0] p, input logic [3:0] g,
                                             input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic [3:0] nibble_sum(input logic [3:0] p, input logic [3:0] c,
                                            input logic ci);
    return p ^ {c[2:0], ci};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               accept_s;
  logic               step_s;
  logic               last_s;
  logic [3:0]         p_s;
  logic [3:0]         g_s;
  logic [3:0]         c_s;
  logic [3:0]         nib_s;
  logic [WIDTH-1:0]   sum_next_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d  = RUN;
          accept_s = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          last_s  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The slice always looks at the low nibble; operands shift right as each nibble retires.
  always_comb begin
    p_s        = a_q[3:0] ^ b_q[3:0];
    g_s        = a_q[3:0] & b_q[3:0];
    c_s        = cla_carries(p_s, g_s, carry_q);
    nib_s      = nibble_sum(p_s, c_s, carry_q);
    sum_next_s = {nib_s, sum_q[WIDTH-1:4]};
  end

  // Datapath next-state: latch on accept, advance one nibble per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept_s) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      idx_d   = {IDX_W{1'b0}};
    end else if (step_s) begin
      a_d     = {4'b0000, a_q[WIDTH-1:4]};
      b_d     = {4'b0000, b_q[WIDTH-1:4]};
      sum_d   = sum_next_s;
      carry_d = c_s[3];
      if (last_s) begin
        idx_d  = {IDX_W{1'b0}};
        cout_d = c_s[3];
        ovf_d  = c_s[2] ^ c_s[3];
        zero_d = (sum_next_s == {WIDTH{1'b0}});
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;

endmodule
